uart_fifo_sync: RTL
===================

# uart_fifo_sync

Parametrised synchronous FIFO, successor to the fixed 8-bit/16-entry UART buffer, for both the UART TX and RX paths between the bus-side register interface and the UART shifters. Adds:
- Configurable width and depth, with all 2^DEPTH_LOG2 entries usable.
- Registered full/empty, level count, and programmable almost-full/almost-empty thresholds.
- Sticky overflow/underflow error flags, a synchronous flush, and a selectable show-ahead (FWFT) or registered read mode.

## Interface
Parameters:
- DATA_W, 8: data word width.
- DEPTH_LOG2, 4: log2 of entry count; DEPTH = 2^DEPTH_LOG2.
- AFULL_THRESH, 12: almost_full asserted when count >= AFULL_THRESH (1..DEPTH).
- AEMPTY_THRESH, 2: almost_empty asserted when count <= AEMPTY_THRESH (0..DEPTH-1).
- FWFT, 1: 1 = show-ahead read data; 0 = registered read data, one-cycle latency.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous empty of FIFO contents.
- wr_en  in  1  push request.
- wr_data  in  DATA_W  push data.
- rd_en  in  1  pop request.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data holds a valid word (see Operation).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.
- err_clr  in  1  clears overflow and underflow.

## Operation
- Storage: DEPTH x DATA_W array, not reset. Read and write pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0. Count is a separate DEPTH_LOG2+1 bit register.
- Push accepted iff wr_en && !full, with full sampled before the edge. A push while full is dropped, sets overflow, and leaves memory, pointer and count unchanged. This holds even when rd_en is accepted in the same cycle: the read proceeds and the write is still dropped.
- Pop accepted iff rd_en && !empty. A pop while empty sets underflow and changes nothing. If wr_en arrives in that same cycle, the write is still accepted.
- Accepted push and accepted pop in the same cycle: both pointers advance and count is unchanged.
- Count update: +1 for a push only, -1 for a pop only, 0 otherwise. Count never exceeds DEPTH and never goes below 0.
- full, empty, almost_full and almost_empty are registered and derived from the next-state count, so they are always consistent with count in the same cycle.
- Priority, highest first: reset > flush > push/pop.
- flush: pointers and count go to 0 and full/empty/almost flags go to their reset values. wr_en/rd_en are ignored that cycle and no errors are flagged. overflow/underflow and the FWFT=0 rd_data register are not cleared.
- err_clr: clears both sticky flags. A set event in the same cycle wins, so the flag stays 1.
- FWFT=1: rd_data = mem[rd_ptr] combinationally, and rd_valid = !empty. rd_data is don't-care while empty. A pop consumes the word currently presented.
- FWFT=0: on an accepted pop, the register takes rd_data <= mem[rd_ptr] and rd_valid pulses 1 for exactly the following cycle. Otherwise rd_valid = 0 and rd_data holds its last value.

## Timing
- Reset values: count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, rd_valid=0, rd_data=0 (FWFT=0). Both pointers are 0.
- Write-to-read latency: a word pushed at edge N is visible on rd_data (FWFT=1) and poppable from cycle N+1.
- FWFT=0 read latency: rd_en accepted at edge N gives data and rd_valid=1 during cycle N+1. Back-to-back pops give back-to-back rd_valid.
- Flags and count change only on clock edges, one edge after the accepted operation.
- Reset or flush during back-to-back traffic: takes effect at that edge, and no push/pop from that cycle is committed.

## Test plan
- Reset, defaults: assert reset for 2 cycles, then check count=0, empty=1, almost_empty=1, full=0, rd_valid=0, overflow=underflow=0.
- Fill/overflow: push 0x00..0x10 (17 words), then check full=1 after the 16th push, almost_full=1 after the 12th, overflow=1 after the 17th, and count=16. Drain 16 words and check the order is 0x00..0x0F.
- Wrap-around: push 10, pop 10, push 16 words 0xA0..0xAF, pop all 16 and check order preserved and empty=1 at the end.
- Simultaneous: with count=5, hold wr_en and rd_en for 8 cycles and check count stays 5 and data order is preserved. With count=16 (full), do wr_en+rd_en and check count=15 and overflow=1.
- Underflow and clear: pop while empty and check underflow=1 and count=0. Assert err_clr with rd_en in the same cycle and check underflow stays 1. err_clr alone then clears it.
- Flush and FWFT=0 mode: with count=7, assert flush and check count=0, empty=1, overflow retained. With FWFT=0, push 0x55, pop at edge N, and check rd_data=0x55 with rd_valid=1 only in cycle N+1.

Source files
------------

// File: rtl/uart_fifo_sync.sv
// Parametrised synchronous FIFO for the UART TX/RX paths: registered status flags,
// sticky error flags, synchronous flush and selectable show-ahead or registered read data.
module uart_fifo_sync #(
  parameter int DATA_W        = 8,
  parameter int DEPTH_LOG2    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ovf_set;
  logic                  unf_set;

  // Handshake: a push is taken on a rising edge iff wr_en && !full, a pop iff
  // rd_en && !empty (flags as registered before the edge); a refused request only
  // raises the matching sticky error flag. flush overrides both and flags nothing.
  always_comb begin
    push_ok    = wr_en && !full && !flush;
    pop_ok     = rd_en && !empty && !flush;
    ovf_set    = wr_en && full && !flush;
    unf_set    = rd_en && empty && !flush;
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      // Flags follow the next-state count so they never lag count itself.
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      overflow     <= ovf_set | (overflow & ~err_clr);
      underflow    <= unf_set | (underflow & ~err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = !empty;
  end else begin : g_reg
    // The data register survives flush so the last delivered word stays visible.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= pop_ok;
        if (pop_ok) rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule
